uart_sender: RTL and testbench
==============================

UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit, legal minimum 2.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 Parameter MSB_FIRST, default 1; 1 shifts data MSB first, 0 shifts LSB first.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clks  input  1  rising-edge clock.
REQ-007 resets  input  1  asynchronous active-high reset.
REQ-008 send  input  1  request to transmit char_to_send.
REQ-009 char_to_send  input  DATA_W  character to transmit, sampled on acceptance.
REQ-010 ready  output  1  high when the one-entry holding buffer is empty.
REQ-011 TxD  output  1  serial line, idle high.
REQ-012 Acks  output  1  high while a frame is on the line or one is buffered.
REQ-013 done  output  1  single-cycle pulse in the last cycle of the final stop bit.

Function
REQ-014 A request SHALL be accepted on a rising edge where send=1 and ready=1; send with ready=0 SHALL be ignored.
REQ-015 Frame states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when the buffer holds a character.
REQ-016 Each START, DATA, PARITY and STOP bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-period counter.
REQ-017 A request accepted in IDLE SHALL drive TxD=0 (start bit) from the next cycle.
REQ-018 DATA SHALL emit DATA_W bits in the order set by MSB_FIRST, from a shift register loaded at frame start.
REQ-019 STOP SHALL drive TxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 A request accepted while a frame is in progress SHALL be stored in the holding buffer and ready SHALL drop to 0.
REQ-021 A buffered character SHALL start its frame in the cycle after done, giving back-to-back frames with no idle gap; ready SHALL return to 1 in that cycle.
REQ-022 If send coincides with done while the buffer is empty, the new character SHALL be treated as buffered and start in the next cycle.
REQ-023 In IDLE with the buffer empty: TxD=1, Acks=0, ready=1.
REQ-024 Changes to char_to_send after acceptance SHALL NOT affect the frame or the buffered character.

Reset
REQ-025 Asserting resets SHALL immediately force TxD=1, Acks=0, done=0, ready=1, state IDLE, buffer empty, and all counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no completion pulse; the first request after release SHALL start a fresh frame.

Configuration
REQ-027 Macro SENDER_PARITY_EN defined: a PARITY state SHALL follow DATA and emit one even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles.
REQ-028 Macro SENDER_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL be followed directly by STOP.

Verification
REQ-029 Single frame: DATA_W=8, CLKS_PER_BIT=4, MSB_FIRST=1, no parity, send 0xA5 -> TxD = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses at cycle 40; Acks is high for cycles 1..40.
REQ-030 Parity: same settings with SENDER_PARITY_EN, send 0xA5 then 0x07 -> parity bits 0 then 1; each frame is 44 cycles.
REQ-031 Back-to-back: send 0x3C, then 0xC3 at cycle 10 -> ready=0 from cycle 11; the second start bit begins in the cycle after the first done; no idle-high gap on TxD.
REQ-032 Overflow: with a frame active and the buffer full, send 0xFF -> request ignored; only the two earlier characters appear on TxD.
REQ-033 Reset mid-frame: assert resets at cycle 15 of a frame -> TxD=1 and Acks=0 in the same cycle; no done pulse; the next send of 0x55 produces a correct full frame.
REQ-034 LSB-first with 2 stop bits: MSB_FIRST=0, STOP_BITS=2, send 0x01 -> TxD = 0,1,0,0,0,0,0,0,0,1,1, each bit held 4 cycles.

Source files
------------

// File: rtl/uart_sender.sv
// uart_sender: serial frame transmitter with a one-entry holding buffer.
// Frame: start bit (0), DATA_W data bits in MSB_FIRST order, optional
// even-parity bit, STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT
// clocks. A character buffered during a frame starts immediately after
// the frame's final stop bit, so back-to-back frames leave no idle gap.
// Optional feature: define SENDER_PARITY_EN to insert the parity bit.
module uart_sender #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic              clks,
  input  logic              resets,
  input  logic              send,
  input  logic [DATA_W-1:0] char_to_send,
  output logic              ready,
  output logic              TxD,
  output logic              Acks,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SENDER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;     // cycles elapsed in the current bit
  logic [IDX_W-1:0]  idx;         // data bit index, or stop bit index
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] buf_data;
  logic              buf_valid;
`ifdef SENDER_PARITY_EN
  logic              parity_bit;
`endif

  logic              bit_last;
  logic              data_last;
  logic              stop_last;
  logic              accept;
  logic              start_frame;
  logic [DATA_W-1:0] start_data;
  logic              data_bit;

  assign bit_last  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign data_last = (idx == IDX_W'(DATA_W - 1));
  assign stop_last = (idx == IDX_W'(STOP_BITS - 1));

  assign ready  = ~buf_valid;
  assign Acks   = (state != S_IDLE) || buf_valid;
  assign done   = (state == S_STOP) && bit_last && stop_last;
  assign accept = send && ready;

  // A frame starts from IDLE on acceptance, or right after done when a
  // character is buffered or is being offered in the done cycle itself.
  assign start_frame = ((state == S_IDLE) && accept) ||
                       (done && (buf_valid || accept));
  assign start_data  = buf_valid ? buf_data : char_to_send;

  assign data_bit = MSB_FIRST ? shift_reg[DATA_W-1] : shift_reg[0];

  // Serial line value decoded from the current frame state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    TxD = 1'b1;
    case (state)
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = data_bit;
`ifdef SENDER_PARITY_EN
      S_PARITY: TxD = parity_bit;
`endif
      default:  TxD = 1'b1;
    endcase
  end

  // Frame sequencer: state, bit-period counter, bit index and shifter.
  always_ff @(posedge clks or posedge resets) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (resets) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift_reg <= '0;
`ifdef SENDER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (start_frame) begin
      state     <= S_START;
      bit_cnt   <= '0;
      idx       <= '0;
      shift_reg <= start_data;
`ifdef SENDER_PARITY_EN
      parity_bit <= ^start_data;
`endif
    end else if (state != S_IDLE) begin
      if (!bit_last) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= '0;
        case (state)
          S_START: begin
            state <= S_DATA;
            idx   <= '0;
          end
          S_DATA: begin
            shift_reg <= MSB_FIRST ? {shift_reg[DATA_W-2:0], 1'b0}
                                   : {1'b0, shift_reg[DATA_W-1:1]};
            if (data_last) begin
              idx   <= '0;
`ifdef SENDER_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
`ifdef SENDER_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            idx   <= '0;
          end
`endif
          S_STOP: begin
            if (stop_last) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  // Holding buffer: filled by a request during a frame, drained at done.
  always_ff @(posedge clks or posedge resets) begin
    if (resets) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (done && buf_valid) begin
      buf_valid <= 1'b0;
    end else if (accept && (state != S_IDLE) && !done) begin
      buf_valid <= 1'b1;
      buf_data  <= char_to_send;
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: drives uart_sender with directed and random requests and
// compares the line against a sample-level model: every accepted character
// becomes a queue of expected TxD samples, plus a one-entry pending slot.
module tb_uart_sender;

  localparam int CPB   = 4;
  localparam int STOPS = 1;
`ifdef SENDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = (1 + 8 + PAR + STOPS) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] char_to_send;
  logic       ready, txd, acks, done;

  logic       send2;
  logic [7:0] char2;
  logic       ready2, txd2, acks2, done2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = -1;

  // Reference model state
  logic       cur_q[$];
  logic       pend = 1'b0;
  logic [7:0] pend_data = '0;

  uart_sender #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(STOPS), .MSB_FIRST(1'b1)) dut (
    .clks(clk), .resets(rst), .send(send), .char_to_send(char_to_send),
    .ready(ready), .TxD(txd), .Acks(acks), .done(done)
  );

  uart_sender #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clks(clk), .resets(rst), .send(send2), .char_to_send(char2),
    .ready(ready2), .TxD(txd2), .Acks(acks2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Append the full line waveform of one MSB-first frame to the model.
  function automatic void push_frame(input logic [7:0] ch);
    logic b;
    for (int k = 0; k < CPB; k++) cur_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = ch[7-i];
      for (int k = 0; k < CPB; k++) cur_q.push_back(b);
    end
`ifdef SENDER_PARITY_EN
    b = ^ch;
    for (int k = 0; k < CPB; k++) cur_q.push_back(b);
`endif
    for (int k = 0; k < STOPS * CPB; k++) cur_q.push_back(1'b1);
  endfunction

  // Advance the model across one rising edge with the given request.
  function automatic void model_edge(input logic s, input logic [7:0] c);
    logic acc;
    acc = s && !pend;
    if (cur_q.size() > 0) void'(cur_q.pop_front());
    if (cur_q.size() == 0) begin
      if (pend) begin
        push_frame(pend_data);
        pend = 1'b0;
      end else if (acc) begin
        push_frame(c);
      end
    end else if (acc) begin
      pend      = 1'b1;
      pend_data = c;
    end
  endfunction

  // One clock cycle: check outputs mid-cycle, then drive this cycle's inputs.
  task automatic step(input logic s, input logic [7:0] c);
    logic exp_txd;
    @(negedge clk);
    exp_txd = (cur_q.size() > 0) ? cur_q[0] : 1'b1;
    check("txd",   32'(txd),   32'(exp_txd));
    check("acks",  32'(acks),  32'((cur_q.size() > 0) || pend));
    check("ready", 32'(ready), 32'(!pend));
    check("done",  32'(done),  32'(cur_q.size() == 1));
    if (done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
    end
    send         = s;
    char_to_send = c;
    model_edge(s, c);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  // Assert reset part-way through the current cycle and check it acts at once.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    check("rst_txd",   32'(txd),   32'(1'b1));
    check("rst_acks",  32'(acks),  32'(1'b0));
    check("rst_done",  32'(done),  32'(1'b0));
    check("rst_ready", 32'(ready), 32'(1'b1));
    cur_q.delete();
    pend = 1'b0;
    send = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int c0;
    int d0;
    logic       lsb_bits[$];
    logic [7:0] lsb_ch;

    rst = 1'b1; send = 1'b0; char_to_send = '0; send2 = 1'b0; char2 = '0;
    repeat (2) @(negedge clk);
    check("reset_txd",   32'(txd),    32'(1'b1));
    check("reset_acks",  32'(acks),   32'(1'b0));
    check("reset_ready", 32'(ready),  32'(1'b1));
    check("reset_done",  32'(done),   32'(1'b0));
    check("reset_txd2",  32'(txd2),   32'(1'b1));
    check("reset_ready2",32'(ready2), 32'(1'b1));
    rst = 1'b0;

    // Single frame 0xA5, then 0x07 (parity 0 then 1 when enabled).
    c0 = cyc;
    step(1'b1, 8'hA5);
    idle(FRAME_LEN + 3);
    check("done_at_a5", 32'(last_done_cyc - c0), 32'(FRAME_LEN));
    c0 = cyc;
    step(1'b1, 8'h07);
    idle(FRAME_LEN + 3);
    check("done_at_07", 32'(last_done_cyc - c0), 32'(FRAME_LEN));

    // Back-to-back 0x3C / 0xC3, then 0xFF while the buffer is full.
    c0 = cyc;
    d0 = done_count;
    step(1'b1, 8'h3C);
    idle(9);
    step(1'b1, 8'hC3);
    idle(9);
    step(1'b1, 8'hFF);
    idle(2 * FRAME_LEN + 5);
    check("b2b_done_count", 32'(done_count - d0), 32'd2);
    check("b2b_done_at", 32'(last_done_cyc - c0), 32'(2 * FRAME_LEN));

    // Request offered exactly in the done cycle with the buffer empty.
    c0 = cyc;
    step(1'b1, 8'h96);
    idle(FRAME_LEN - 1);
    step(1'b1, 8'h69);
    idle(FRAME_LEN + 5);
    check("coinc_done_at", 32'(last_done_cyc - c0), 32'(2 * FRAME_LEN));

    // Reset in cycle 15 of a frame, then a clean 0x55 frame.
    d0 = done_count;
    step(1'b1, 8'h5A);
    idle(15);
    reset_mid();
    idle(3);
    c0 = cyc;
    step(1'b1, 8'h55);
    idle(FRAME_LEN + 3);
    check("rst_done_count", 32'(done_count - d0), 32'd1);
    check("rst_done_at", 32'(last_done_cyc - c0), 32'(FRAME_LEN));

    // LSB-first, two stop bits, 0x01 on the second instance.
    lsb_ch = 8'h01;
    for (int k = 0; k < CPB; k++) lsb_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) lsb_bits.push_back(lsb_ch[i]);
`ifdef SENDER_PARITY_EN
    for (int k = 0; k < CPB; k++) lsb_bits.push_back(^lsb_ch);
`endif
    for (int k = 0; k < 2 * CPB; k++) lsb_bits.push_back(1'b1);
    @(negedge clk);
    send2 = 1'b1; char2 = lsb_ch;
    @(negedge clk);
    send2 = 1'b0; char2 = 8'hFE;
    for (int j = 0; j < lsb_bits.size(); j++) begin
      check("lsb_txd",  32'(txd2),  32'(lsb_bits[j]));
      check("lsb_acks", 32'(acks2), 32'(1'b1));
      check("lsb_done", 32'(done2), 32'(j == lsb_bits.size() - 1));
      @(negedge clk);
    end
    check("lsb_idle_txd",  32'(txd2),  32'(1'b1));
    check("lsb_idle_acks", 32'(acks2), 32'(1'b0));

    // Random traffic with occasional mid-frame resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom));
      if ($urandom_range(0, 799) == 0) reset_mid();
    end
    idle(2 * FRAME_LEN + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
